trellis_phase_detector: RTL and testbench

Decision-directed carrier phase detector for the SOQPSK/trellis path. It sits downstream of the trellis carrier loop's derotator and consumes the derotated iOut/qOut with the delayed symbol strobe. It forms a per-symbol cross-product phase error, averages it over 2^avgExp symbols, and returns a saturated 8-bit phaseError with a one-cycle symEn_phErr strobe, which closes the carrier loop.

---
 rtl/trellis_phase_detector.sv | 104 ++++++++++
 tb/tb_trellis_phase_detector.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/trellis_phase_detector.sv
// Decision-directed carrier phase detector for the SOQPSK/trellis path.
// Cross-product error per symbol, block-averaged over 2^avgExp symbols, saturated to ERR_W bits.
module trellis_phase_detector #(
    parameter int IN_W    = 18,
    parameter int ERR_W   = 8,
    parameter int MAX_EXP = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    symEn,
    input  logic [IN_W-1:0]         iIn,
    input  logic [IN_W-1:0]         qIn,
    input  logic [1:0]              avgExp,
    input  logic                    restart,
    output logic signed [ERR_W-1:0] phaseError,
    output logic                    symEn_phErr
);
    localparam int ACC_W = IN_W + 1 + MAX_EXP;
    localparam int SHIFT = IN_W - ERR_W;
    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1 << (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (ERR_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(1 << (ERR_W - 1));

    logic [IN_W-1:0]          iReg, qReg;
    logic                     v1, v2, dump;
    logic signed [IN_W:0]     errReg, errNext;
    logic signed [IN_W:0]     iExt, qExt, qTerm, iTerm;
    logic signed [ACC_W-1:0]  accReg, accSum, avgVal, roundVal;
    logic [MAX_EXP-1:0]       cnt, lastCnt;
    logic [1:0]               expL, expEff;
    logic                     lastSym;
    logic signed [ERR_W-1:0]  satVal;

    // Slicer decisions: sign bit only, so zero is treated as +1.
    always_comb begin
        iExt    = $signed({iReg[IN_W-1], iReg});
        qExt    = $signed({qReg[IN_W-1], qReg});
        qTerm   = iReg[IN_W-1] ? -qExt : qExt;
        iTerm   = qReg[IN_W-1] ? -iExt : iExt;
        errNext = qTerm - iTerm;
    end

    // The first symbol of a block sees the live avgExp; later ones the latched copy.
    always_comb begin
        expEff  = (cnt == '0) ? avgExp : expL;
        lastCnt = MAX_EXP'((1 << expEff) - 1);
        lastSym = (cnt == lastCnt);
        accSum  = ((cnt == '0) ? '0 : accReg) + $signed({{MAX_EXP{errReg[IN_W]}}, errReg});
    end

    always_comb begin
        avgVal   = accReg >>> expL;
        roundVal = (avgVal + HALF) >>> SHIFT;
        if (roundVal > SAT_MAX)
            satVal = SAT_MAX[ERR_W-1:0];
        else if (roundVal < SAT_MIN)
            satVal = SAT_MIN[ERR_W-1:0];
        else
            satVal = roundVal[ERR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iReg        <= '0;
            qReg        <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            errReg      <= '0;
            accReg      <= '0;
            cnt         <= '0;
            expL        <= '0;
            dump        <= 1'b0;
            phaseError  <= '0;
            symEn_phErr <= 1'b0;
        end else begin
            if (symEn) begin
                iReg <= iIn;
                qReg <= qIn;
            end
            v1     <= symEn && !restart;
            v2     <= v1 && !restart;
            errReg <= errNext;

            if (restart) begin
                accReg <= '0;
                cnt    <= '0;
                dump   <= 1'b0;
            end else if (v2) begin
                accReg <= accSum;
                cnt    <= lastSym ? '0 : cnt + MAX_EXP'(1);
                if (cnt == '0)
                    expL <= avgExp;
                dump   <= lastSym;
            end else begin
                dump   <= 1'b0;
            end

            // A dump pending when restart arrives belongs to a discarded block.
            symEn_phErr <= dump && !restart;
            if (dump && !restart)
                phaseError <= satVal;
        end
    end
endmodule

// File: tb/tb_trellis_phase_detector.sv
// Bench for trellis_phase_detector: directed steps plus random traffic,
// checked every cycle against a block-averaging reference model.
module tb_trellis_phase_detector;
    logic              clk = 1'b0;
    logic              reset, symEn, restart;
    logic [17:0]       iIn, qIn;
    logic [1:0]        avgExp;
    logic signed [7:0] phaseError;
    logic              symEn_phErr;

    int checks = 0;
    int errors = 0;

    trellis_phase_detector dut (
        .clk(clk), .reset(reset), .symEn(symEn), .iIn(iIn), .qIn(qIn),
        .avgExp(avgExp), .restart(restart),
        .phaseError(phaseError), .symEn_phErr(symEn_phErr)
    );

    always #5 clk = ~clk;

    // Reference model: symbols join the current block two cycles after entry,
    // a finished block yields a strobe two cycles after its last symbol joins.
    typedef struct { int c; int i; int q; } sym_t;
    typedef struct { int c; logic [7:0] v; } stb_t;
    sym_t       infl[$];
    stb_t       stq[$];
    int         blkSum = 0, blkCnt = 0, blkExp = 0, cyc = 0;
    logic [7:0] expPhase = 8'h00;
    logic       expStrobe = 1'b0;

    function automatic int errOf(int i, int q);
        return ((i < 0) ? -q : q) - ((q < 0) ? -i : i);
    endfunction

    function automatic logic [7:0] quant(int sum, int e);
        int avg, r;
        avg = sum >>> e;
        r = (avg + 512) >>> 10;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return 8'(r);
    endfunction

    task automatic step(string tag, bit s, int i, int q, int e, bit rs, bit rst);
        logic signed [17:0] iv, qv;
        sym_t sy;
        stb_t sb;
        symEn = s; iIn = 18'(i); qIn = 18'(q); avgExp = 2'(e);
        restart = rs; reset = rst;
        iv = iIn; qv = qIn;
        if (rst) begin
            infl.delete(); stq.delete();
            blkSum = 0; blkCnt = 0; expPhase = 8'h00; expStrobe = 1'b0;
        end else if (rs) begin
            infl.delete(); stq.delete();
            blkSum = 0; blkCnt = 0; expStrobe = 1'b0;
        end else begin
            while (infl.size() > 0 && infl[0].c == cyc - 2) begin
                sy = infl.pop_front();
                if (blkCnt == 0) blkExp = e;
                blkSum += errOf(sy.i, sy.q);
                blkCnt++;
                if (blkCnt == (1 << blkExp)) begin
                    sb.c = cyc + 2; sb.v = quant(blkSum, blkExp);
                    stq.push_back(sb);
                    blkSum = 0; blkCnt = 0;
                end
            end
            if (s) begin
                sy.c = cyc; sy.i = int'(iv); sy.q = int'(qv);
                infl.push_back(sy);
            end
            if (stq.size() > 0 && stq[0].c == cyc + 1) begin
                sb = stq.pop_front();
                expPhase = sb.v; expStrobe = 1'b1;
            end else begin
                expStrobe = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        assert (symEn_phErr === expStrobe) else begin
            errors++;
            $error("FAIL %s cyc %0d symEn_phErr got %b exp %b", tag, cyc, symEn_phErr, expStrobe);
        end
        checks++;
        assert (phaseError === expPhase) else begin
            errors++;
            $error("FAIL %s cyc %0d phaseError got %h exp %h", tag, cyc, phaseError, expPhase);
        end
        if (symEn_phErr === 1'b1)
            $display("%s cyc %0d strobe phaseError=%h", tag, cyc, phaseError);
    endtask

    task automatic idle(string tag, int n, int e);
        for (int k = 0; k < n; k++) step(tag, 0, 0, 0, e, 0, 0);
    endtask

    initial begin
        step("reset", 0, 0, 0, 0, 0, 1);
        step("reset", 0, 0, 0, 0, 0, 1);
        idle("reset", 2, 0);

        // Single symbol, no averaging: -57344 -> 0xC8
        step("t1", 1, 'h10000, 'h02000, 0, 0, 0);
        idle("t1", 5, 0);
        checks++;
        assert (phaseError === 8'hC8) else begin
            errors++;
            $error("FAIL t1_const phaseError got %h exp c8", phaseError);
        end

        // Saturation at both rails
        step("t2a", 1, 'h00000, 'h1FFFF, 0, 0, 0);
        idle("t2a", 5, 0);
        step("t2b", 1, 'h00000, 'h20000, 0, 0, 0);
        idle("t2b", 5, 0);

        // Four back-to-back symbols averaged into one strobe
        for (int k = 0; k < 4; k++) step("t3", 1, 0, 1024, 2, 0, 0);
        idle("t3", 6, 2);
        checks++;
        assert (phaseError === 8'h01) else begin
            errors++;
            $error("FAIL t3_const phaseError got %h exp 01", phaseError);
        end

        // avgExp change mid-block applies to the next block
        step("t4", 1, 'h08000, 'h3F000, 1, 0, 0);
        idle("t4", 3, 1);
        step("t4", 1, 'h08000, 'h3F000, 3, 0, 0);
        for (int k = 0; k < 8; k++) step("t4", 1, 'h01000, 'h0C000, 3, 0, 0);
        idle("t4", 6, 3);

        // Restart drops a partial block and the coincident symbol
        for (int k = 0; k < 3; k++) step("t5", 1, 'h3A000, 'h05000, 2, 0, 0);
        step("t5", 1, 'h3A000, 'h05000, 2, 1, 0);
        idle("t5", 6, 2);
        for (int k = 0; k < 4; k++) step("t5", 1, 'h02000, 'h1C000, 2, 0, 0);
        idle("t5", 6, 2);

        // Reset mid-block, then a fresh block
        for (int k = 0; k < 2; k++) step("t6", 1, 'h00100, 'h30000, 2, 0, 0);
        step("t6", 0, 0, 0, 2, 0, 1);
        for (int k = 0; k < 4; k++) step("t6", 1, 'h10000, 'h00400, 2, 0, 0);
        idle("t6", 6, 2);

        // Random traffic with occasional exponent changes and restarts
        begin
            int e = 0;
            for (int k = 0; k < 600; k++) begin
                if ($urandom_range(0, 29) == 0) e = $urandom_range(0, 3);
                step("rnd", bit'($urandom_range(0, 1)), int'($urandom_range(0, 262143)),
                     int'($urandom_range(0, 262143)), e, ($urandom_range(0, 49) == 0), 1'b0);
            end
            idle("rnd", 8, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
